// File: rtl/fetch_prefetch_buf.sv
// fetch_prefetch_buf
//   Instruction prefetch stage in front of decode/execute. It issues word
//   fetches on a req/gnt/rvalid bus, keeps the PC of every granted request
//   in a small in-order queue, and buffers returned words with their PCs
//   in a FIFO that feeds the core over a valid/ready handshake. It supports
//   a PC redirect (flush) and a halt.
//
// Ports
//   clk, rst_i                     clock (rising edge), async active-low reset
//   halt                           stop issuing new requests (sampled between requests)
//   redirect_valid, redirect_pc    1-cycle flush + restart at redirect_pc (bits[1:0] ignored)
//   imem_req, imem_addr            fetch request and word-aligned address
//   imem_gnt                       request accepted when imem_req & imem_gnt
//   imem_rvalid, imem_rdata        in-order response, at least 1 cycle after gnt
//   out_valid, out_ready           handshake towards the core
//   out_pc, out_instr              presented PC and instruction word
//   dbg_state                      current fetch FSM state (IDLE=0, REQ=1, WAIT=2)
//
// Handshakes: a transfer happens on a rising edge where the sender's
//   valid (imem_req / out_valid) and the receiver's accept (imem_gnt /
//   out_ready) are both 1. An un-granted imem_req keeps its address stable
//   until granted, except that a redirect withdraws it.
//
// Optional build macro PREFETCH_BYPASS_EN: when the FIFO is empty and an
//   accepted response arrives, it is presented on out_* in the same cycle;
//   if out_ready is also 1 the word is consumed and never stored. Without
//   the macro every out_* signal comes from registers only.

module fetch_prefetch_buf #(
    parameter int              DEPTH    = 4,
    parameter int              AW       = 32,
    parameter logic [AW-1:0]   RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst_i,
    input  logic          halt,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_pc,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_gnt,
    input  logic          imem_rvalid,
    input  logic [31:0]   imem_rdata,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_pc,
    output logic [31:0]   out_instr,
    output logic [1:0]    dbg_state
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] L_DEPTH = (CW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_fetch_pc;
    logic [CW-1:0]   r_inflight;
    logic [CW-1:0]   r_discard;
    logic [CW-1:0]   r_count;
    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_pcq_rd;
    logic [PW-1:0]   r_pcq_wr;
    logic [AW-1:0]   r_pcq        [DEPTH];
    logic [AW-1:0]   r_fifo_pc    [DEPTH];
    logic [31:0]     r_fifo_instr [DEPTH];

    logic            w_gnt_hs;
    logic            w_accept;
    logic            w_bypass;
    logic            w_bypass_take;
    logic            w_push;
    logic            w_pop;
    logic            w_credit;
    logic [CW-1:0]   w_inflight_nxt;
    logic [CW-1:0]   w_count_nxt;
    logic [CW:0]     w_sum_nxt;
    logic [AW-1:0]   w_rsp_pc;
    logic [AW-1:0]   w_redirect_pc;

    assign w_gnt_hs      = imem_req & imem_gnt;
    assign w_rsp_pc      = r_pcq[r_pcq_rd];
    assign w_redirect_pc = redirect_pc & ~AW'(3);
    // Responses owed to a flushed stream are dropped while r_discard > 0.
    assign w_accept      = imem_rvalid && (r_discard == '0);

`ifdef PREFETCH_BYPASS_EN
    // IDLE only occurs right after reset, when nothing can be in flight; the
    // state gate keeps a stale rvalid from showing through during reset.
    assign w_bypass      = w_accept && (r_count == '0) && !redirect_valid && (r_state != S_IDLE);
    assign w_bypass_take = w_bypass && out_ready;
`else
    assign w_bypass      = 1'b0;
    assign w_bypass_take = 1'b0;
`endif

    assign w_push         = w_accept && !w_bypass_take && !redirect_valid;
    assign w_pop          = (r_count != '0) && out_ready;
    assign w_count_nxt    = r_count + CW'(w_push) - CW'(w_pop);
    assign w_inflight_nxt = r_inflight + CW'(w_gnt_hs) - CW'(imem_rvalid);
    // Credit is judged on next-cycle occupancy so a pop or response this cycle
    // frees a slot immediately.
    assign w_sum_nxt      = {1'b0, w_inflight_nxt} + {1'b0, w_count_nxt};
    assign w_credit       = (w_sum_nxt < L_DEPTH);

    assign imem_addr = r_fetch_pc;
    assign dbg_state = r_state;

    // ---------------- fetch FSM ----------------
    always_comb begin
        w_state_nxt = r_state;
        imem_req    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_credit && !halt) w_state_nxt = S_REQ;
            end
            S_REQ: begin
                imem_req = 1'b1;
                // halt is only looked at once the current request is granted.
                if (imem_gnt) w_state_nxt = (w_credit && !halt) ? S_REQ : S_WAIT;
            end
            S_WAIT: begin
                if (w_credit && !halt) w_state_nxt = S_REQ;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (redirect_valid) w_state_nxt = S_WAIT;
    end

    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= RESET_PC;
            r_inflight <= '0;
            r_discard  <= '0;
            r_pcq_rd   <= '0;
            r_pcq_wr   <= '0;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= w_inflight_nxt;

            if (redirect_valid)  r_fetch_pc <= w_redirect_pc;
            else if (w_gnt_hs)   r_fetch_pc <= r_fetch_pc + AW'(4);

            // Every in-flight request at the redirect edge, including one
            // granted in that same cycle, belongs to the old stream.
            if (redirect_valid)                         r_discard <= w_inflight_nxt;
            else if (imem_rvalid && r_discard != '0)    r_discard <= r_discard - CW'(1);

            // The PC queue tracks every response, dropped or not.
            if (w_gnt_hs)    r_pcq_wr <= r_pcq_wr + PW'(1);
            if (imem_rvalid) r_pcq_rd <= r_pcq_rd + PW'(1);

            if (redirect_valid) begin
                r_count  <= '0;
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                r_count <= w_count_nxt;
                if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            end
        end
    end

    // Storage arrays need no reset; pointers and counts qualify them.
    always_ff @(posedge clk) begin
        if (w_gnt_hs) r_pcq[r_pcq_wr] <= imem_addr;
        if (w_push) begin
            r_fifo_pc[r_wr_ptr]    <= w_rsp_pc;
            r_fifo_instr[r_wr_ptr] <= imem_rdata;
        end
    end

    // ---------------- output ----------------
    always_comb begin
        out_valid = 1'b0;
        out_pc    = '0;
        out_instr = '0;
        if (r_count != '0) begin
            out_valid = 1'b1;
            out_pc    = r_fifo_pc[r_rd_ptr];
            out_instr = r_fifo_instr[r_rd_ptr];
        end
`ifdef PREFETCH_BYPASS_EN
        else if (w_bypass) begin
            out_valid = 1'b1;
            out_pc    = w_rsp_pc;
            out_instr = imem_rdata;
        end
`endif
    end

endmodule

// File: tb/tb_fetch_prefetch_buf.sv
// Self-checking bench for fetch_prefetch_buf (DEPTH=4, AW=32, RESET_PC=0x100).
// A simple in-order memory answers each granted request one cycle later;
// instruction words are a fixed function of the address.

module tb_fetch_prefetch_buf;

    localparam logic [31:0] RPC = 32'h100;
`ifdef PREFETCH_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif

    logic        clk;
    logic        rst_i;
    logic        halt;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [1:0]  dbg_state;

    fetch_prefetch_buf #(
        .DEPTH    (4),
        .AW       (32),
        .RESET_PC (32'h100)
    ) dut (
        .clk            (clk),
        .rst_i          (rst_i),
        .halt           (halt),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .dbg_state      (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          gnt_cnt  = 0;
    logic        resp_en  = 1'b0;
    logic [31:0] bus_q[$];
    logic [31:0] obs_pc_q[$];
    logic [31:0] obs_in_q[$];
    logic [31:0] exp_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // ---------------- bus monitor and memory responder ----------------
    always @(negedge clk) begin
        if (rst_i) begin
            if (imem_req && imem_gnt) begin
                gnt_cnt++;
                bus_q.push_back(imem_addr);
            end
            if (out_valid && out_ready) begin
                obs_pc_q.push_back(out_pc);
                obs_in_q.push_back(out_instr);
            end
        end
    end

    initial begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst_i && resp_en && bus_q.size() > 0) begin
                imem_rdata  = mem_word(bus_q.pop_front());
                imem_rvalid = 1'b1;
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = '0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Asserts reset off the clock edge, checks the reset outputs at once,
    // then releases it just after a rising edge (cycle 0 = IDLE).
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2;
        rst_i = 1'b0;
        #1;
        check({tag, "_rst_req"},    imem_req,  0);
        check({tag, "_rst_addr"},   imem_addr, RPC);
        check({tag, "_rst_valid"},  out_valid, 0);
        check({tag, "_rst_pc"},     out_pc,    0);
        check({tag, "_rst_instr"},  out_instr, 0);
        imem_gnt = 1'b0; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        out_ready = 1'b0; resp_en = 1'b0;
        bus_q.delete(); obs_pc_q.delete(); obs_in_q.delete(); gnt_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b1;
    endtask

    // Compares the consumed stream with a sequential run from base.
    task automatic check_stream(input string tag, input logic [31:0] base, input int min_n);
        check({tag, "_count_ok"}, obs_pc_q.size() >= min_n, 1);
        exp_q.delete();
        for (int i = 0; i < obs_pc_q.size(); i++) exp_q.push_back(base + 32'(4 * i));
        for (int i = 0; i < obs_pc_q.size(); i++) begin
            check({tag, "_pc"},    obs_pc_q[i], exp_q[i]);
            check({tag, "_instr"}, obs_in_q[i], mem_word(exp_q[i]));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        rst_i = 1'b0; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        imem_gnt = 1'b0; out_ready = 1'b0;

        // 1: streaming from RESET_PC, one word per cycle
        do_reset("t1");
        imem_gnt = 1'b1; out_ready = 1'b1; resp_en = 1'b1;
        check("t1_idle_req", imem_req, 0);
        check("t1_idle_state", dbg_state, 0);
        wait_cycles(1);
        check("t1_c1_req", imem_req, 1);
        check("t1_c1_addr", imem_addr, 32'h100);
        check("t1_c1_valid", out_valid, 0);
        wait_cycles(1);
        check("t1_c2_addr", imem_addr, 32'h104);
        check("t1_c2_valid", out_valid, BYP);
        wait_cycles(18);
        check("t1_n_out", obs_pc_q.size(), 17 + BYP);
        check_stream("t1", 32'h100, 17 + BYP);

        // 2: consumer stalled -> exactly DEPTH grants, then clean drain
        do_reset("t2");
        imem_gnt = 1'b1; resp_en = 1'b1; out_ready = 1'b0;
        wait_cycles(12);
        check("t2_grants", gnt_cnt, 4);
        check("t2_req_off", imem_req, 0);
        check("t2_valid", out_valid, 1);
        check("t2_head_pc", out_pc, 32'h100);
        check("t2_head_instr", out_instr, mem_word(32'h100));
        out_ready = 1'b1;
        wait_cycles(30);
        check_stream("t2", 32'h100, 20);

        // 3: redirect with three requests in flight
        do_reset("t3");
        imem_gnt = 1'b1; resp_en = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (gnt_cnt >= 3) break;
        end
        check("t3_grants", gnt_cnt, 3);
        wait_cycles(0);
        @(posedge clk);
        #1;
        imem_gnt = 1'b0;
        check("t3_pend_req", imem_req, 1);
        check("t3_pend_addr", imem_addr, 32'h10C);
        redirect_valid = 1'b1; redirect_pc = 32'h2003;
        wait_cycles(1);
        redirect_valid = 1'b0; resp_en = 1'b1;
        check("t3_req_drop", imem_req, 0);
        check("t3_flush_valid", out_valid, 0);
        imem_gnt = 1'b1;
        wait_cycles(1);
        check("t3_new_req", imem_req, 1);
        check("t3_new_addr", imem_addr, 32'h2000);
        wait_cycles(20);
        check_stream("t3", 32'h2000, 6);

        // 4: gnt held low, redirect withdraws the pending request
        do_reset("t4");
        imem_gnt = 1'b0; resp_en = 1'b1; out_ready = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            wait_cycles(1);
            check("t4_hold_req", imem_req, 1);
            check("t4_hold_addr", imem_addr, 32'h100);
        end
        redirect_valid = 1'b1; redirect_pc = 32'h3000;
        wait_cycles(1);
        redirect_valid = 1'b0;
        check("t4_req_drop", imem_req, 0);
        wait_cycles(1);
        check("t4_new_req", imem_req, 1);
        check("t4_new_addr", imem_addr, 32'h3000);
        imem_gnt = 1'b1;
        wait_cycles(1);
        check("t4_next_addr", imem_addr, 32'h3004);
        wait_cycles(15);
        check_stream("t4", 32'h3000, 6);

        // 5: halt with two in flight, then resume
        do_reset("t5");
        imem_gnt = 1'b1; resp_en = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (gnt_cnt >= 2) begin
                halt = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        resp_en = 1'b1;
        wait_cycles(10);
        check("t5_grants", gnt_cnt, 2);
        check("t5_req_off", imem_req, 0);
        check("t5_n_out", obs_pc_q.size(), 2);
        halt = 1'b0;
        wait_cycles(1);
        check("t5_resume_req", imem_req, 1);
        check("t5_resume_addr", imem_addr, 32'h108);
        wait_cycles(10);
        check_stream("t5", 32'h100, 6);

        // 6: asynchronous reset in the middle of a stream
        do_reset("t6a");
        imem_gnt = 1'b1; resp_en = 1'b1; out_ready = 1'b1;
        wait_cycles(10);
        check("t6_running", out_valid, 1);
        do_reset("t6b");
        imem_gnt = 1'b1; resp_en = 1'b1; out_ready = 1'b1;
        wait_cycles(1);
        check("t6_restart_req", imem_req, 1);
        check("t6_restart_addr", imem_addr, 32'h100);
        wait_cycles(15);
        check_stream("t6", 32'h100, 10);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
